instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
// Multi-cycle control sequencer; consumer side of the custom_types instruction encoding.
// Owns PC, IR and Z flag, and steps state_t FETCH->DECODE->EXECUTE->MEMORY_ACCESS->WRITE_BACK.
// Decodes instruction_t {opcode_t, operand_t} into register-file, ALU and data-memory controls.
// Sits between the synchronous instruction memory and the ALU/register datapath.
// PARAMETERS
// PC_WIDTH    8     instruction address width; PC arithmetic wraps mod 2^PC_WIDTH
// DATA_WIDTH  8     datapath width; imm output zero-extended to this width
// RESET_PC    '0    PC value after reset
// PORTS
// clk         in   1           rising-edge clock
// rst         in   1           synchronous, active-high reset
// en          in   1           1: leave FETCH (start next instruction); sampled in FETCH only
// imem_addr   out  PC_WIDTH    = pc; imem_rdata valid one cycle later (sync read)
// imem_rdata  in   8           instruction_t from instruction memory
// alu_zero    in   1           datapath ALU result == 0
// state       out  3           current state_t
// pc          out  PC_WIDTH    program counter
// ir          out  8           instruction register
// rf_raddr_a  out  2           = ir.operand.regs.dst (ALU A / store data)
// rf_raddr_b  out  2           = ir.operand.regs.src (ALU B / load-store address)
// rf_waddr    out  2           = ir.operand.regs.dst
// rf_we       out  1           register write strobe
// alu_op      out  3           alu_operation_t
// alu_b_sel   out  1           0: reg B, 1: imm
// imm         out  DATA_WIDTH  zero-extended imm2.val
// wb_sel      out  2           0 ALU, 1 MEM, 2 REG_B, 3 IMM
// dmem_re     out  1           data memory read strobe
// dmem_we     out  1           data memory write strobe
// z_flag      out  1           zero flag
// illegal     out  1           1-cycle pulse: opcode 0xF decoded
// instr_done  out  1           1-cycle pulse in the last state of every instruction
// BEHAVIOUR
// - Reset: state=FETCH, pc=RESET_PC, ir=0, z_flag=0; all strobes 0. Strobes are gated by !rst,
//   so reset mid-instruction (incl. WRITE_BACK/MEMORY_ACCESS) aborts with no rf_we/dmem_we.
// - FETCH: if en, go to DECODE; else hold. DECODE: ir<=imem_rdata, pc<=pc+1, go to EXECUTE.
// - Decode fields come from ir and are held stable EXECUTE through WRITE_BACK.
// - ALU class (ADD,SUB,AND,OR,XOR: dst op= src; ADDI,SUBI,LSLI: dst op= zext(val)):
//   EXECUTE->WRITE_BACK; rf_we=1, wb_sel=ALU; z_flag<=alu_zero at end of WRITE_BACK. 4 cycles.
// - MOV: wb_sel=REG_B; MOVI: wb_sel=IMM. EXECUTE->WRITE_BACK with rf_we; z_flag unchanged.
// - LD: R[dst]<=mem[R[src]]; EXECUTE->MEMORY_ACCESS (dmem_re=1)->WRITE_BACK (rf_we, wb_sel=MEM). 5 cycles.
// - ST: mem[R[src]]<=R[dst]; EXECUTE->MEMORY_ACCESS (dmem_we=1)->FETCH. 4 cycles.
// - JMP/BEQ/BNE: resolved in EXECUTE, then FETCH. 3 cycles. Target = pc (already incremented) + sext(imm4).
//   JMP always taken; BEQ taken iff z_flag=1; BNE taken iff z_flag=0. Wraps mod 2^PC_WIDTH.
// - Opcode 0xF: illegal=1 in EXECUTE; no writes; behaves as NOP (pc already incremented); then FETCH.
// - instr_done asserted in the final state: WRITE_BACK, MEMORY_ACCESS (ST) or EXECUTE (jumps/illegal).
// - Strobes rf_we, dmem_re and dmem_we are each high for exactly one cycle per instruction and never together.
// TESTING
// - Reset: hold rst 2 cycles -> pc=0, state=FETCH, ir=0, z_flag=0; all strobes 0.
// - MOVI R3,2 (0xBB) at 0x00 -> WRITE_BACK in cycle 4; rf_we=1, rf_waddr=3, wb_sel=3, imm=2; pc=0x01.
// - SUB R0,R0 (0x10) with alu_zero=1 -> z_flag=1. Then BEQ -2 (0x8E) at 0x01 -> pc=0x00 after 3 cycles.
//   The same BEQ with z_flag=0 -> pc=0x02.
// - LD R2,[R1] (0x56) -> dmem_re in cycle 4, rf_we with wb_sel=1 in cycle 5; ST (0x66) -> dmem_we, no rf_we.
// - 0xF3 -> illegal pulse, no strobes, pc+1. JMP +1 (0x71) at pc=0xFF -> pc=0x01 (wrap).
// - rst asserted during WRITE_BACK of ADD -> rf_we=0 that cycle; z_flag=0; state=FETCH, pc=0 next cycle.
// - en=0 holds FETCH indefinitely, with pc stable; en=1 resumes.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction encoding shared with the assembler/instruction memory side,
// followed by the multi-cycle sequencer that consumes it.
//
// Instruction byte layout: {opcode[3:0], operand[3:0]}
//   regs : operand = {src[1:0], dst[1:0]}
//   imm2 : operand = {val[1:0], dst[1:0]}
//   imm4 : operand = signed 4-bit branch offset
package custom_types;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_LD   = 4'h5,
        OP_ST   = 4'h6,
        OP_JMP  = 4'h7,
        OP_BEQ  = 4'h8,
        OP_BNE  = 4'h9,
        OP_MOV  = 4'hA,
        OP_MOVI = 4'hB,
        OP_ADDI = 4'hC,
        OP_SUBI = 4'hD,
        OP_LSLI = 4'hE,
        OP_ILL  = 4'hF
    } opcode_t;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] dst;
    } regs_t;

    typedef struct packed {
        logic [1:0] val;
        logic [1:0] dst;
    } imm2_t;

    typedef union packed {
        regs_t      regs;
        imm2_t      imm2;
        logic [3:0] imm4;
    } operand_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand;
    } instruction_t;

    typedef enum logic [2:0] {
        FETCH         = 3'd0,
        DECODE        = 3'd1,
        EXECUTE       = 3'd2,
        MEMORY_ACCESS = 3'd3,
        WRITE_BACK    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_LSL = 3'd5
    } alu_operation_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_REG = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

endpackage

// instr_sequencer: multi-cycle control FSM owning PC, IR and the Z flag.
// Ports: clk/rst (sync, active-high), en start strobe, sync instruction-memory
//   read port, alu_zero feedback; register-file / ALU / data-memory controls out.
// Latency: ALU/MOV 4 cycles, LD 5, ST 4, jumps/branches/illegal 3. en=0 stalls in FETCH.
module instr_sequencer
    import custom_types::*;
#(
    parameter int                  PC_WIDTH   = 8,
    parameter int                  DATA_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [7:0]            imem_rdata,
    input  logic                  alu_zero,
    output logic [2:0]            state,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [7:0]            ir,
    output logic [1:0]            rf_raddr_a,
    output logic [1:0]            rf_raddr_b,
    output logic [1:0]            rf_waddr,
    output logic                  rf_we,
    output logic [2:0]            alu_op,
    output logic                  alu_b_sel,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [1:0]            wb_sel,
    output logic                  dmem_re,
    output logic                  dmem_we,
    output logic                  z_flag,
    output logic                  illegal,
    output logic                  instr_done
);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q,    pc_d;
    instruction_t        ir_q,    ir_d;
    logic                z_q,     z_d;

    // ------------------------------------------------------------------
    // Decode of the held instruction; stable from EXECUTE to WRITE_BACK
    // because ir only loads in DECODE.
    // ------------------------------------------------------------------
    opcode_t        opc;
    logic           is_alu;       // result from ALU, updates Z
    logic           is_alu_imm;   // ALU B operand is the immediate
    logic           is_mov;
    logic           is_ld;
    logic           is_st;
    logic           is_flow;      // JMP/BEQ/BNE
    logic           is_ill;
    logic           br_taken;
    alu_operation_t alu_op_c;
    wb_sel_t        wb_sel_c;

    assign opc = ir_q.opcode;

    always_comb begin
        is_alu     = 1'b0;
        is_alu_imm = 1'b0;
        is_mov     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_flow    = 1'b0;
        is_ill     = 1'b0;
        br_taken   = 1'b0;
        alu_op_c   = ALU_ADD;
        wb_sel_c   = WB_ALU;
        unique case (opc)
            OP_ADD:  begin is_alu = 1'b1; alu_op_c = ALU_ADD; end
            OP_SUB:  begin is_alu = 1'b1; alu_op_c = ALU_SUB; end
            OP_AND:  begin is_alu = 1'b1; alu_op_c = ALU_AND; end
            OP_OR:   begin is_alu = 1'b1; alu_op_c = ALU_OR;  end
            OP_XOR:  begin is_alu = 1'b1; alu_op_c = ALU_XOR; end
            OP_ADDI: begin is_alu = 1'b1; is_alu_imm = 1'b1; alu_op_c = ALU_ADD; end
            OP_SUBI: begin is_alu = 1'b1; is_alu_imm = 1'b1; alu_op_c = ALU_SUB; end
            OP_LSLI: begin is_alu = 1'b1; is_alu_imm = 1'b1; alu_op_c = ALU_LSL; end
            OP_MOV:  begin is_mov = 1'b1; wb_sel_c = WB_REG; end
            OP_MOVI: begin is_mov = 1'b1; wb_sel_c = WB_IMM; end
            OP_LD:   begin is_ld  = 1'b1; wb_sel_c = WB_MEM; end
            OP_ST:   begin is_st  = 1'b1; end
            OP_JMP:  begin is_flow = 1'b1; br_taken = 1'b1;  end
            OP_BEQ:  begin is_flow = 1'b1; br_taken = z_q;   end
            OP_BNE:  begin is_flow = 1'b1; br_taken = !z_q;  end
            OP_ILL:  begin is_ill  = 1'b1; end
            default: begin is_ill  = 1'b1; end
        endcase
    end

    // Branch offset is relative to the already-incremented PC.
    logic [PC_WIDTH-1:0] br_off;
    assign br_off = {{(PC_WIDTH-4){ir_q.operand.imm4[3]}}, ir_q.operand.imm4};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        unique case (state_q)
            FETCH: begin
                if (en) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // imem_rdata now reflects the address presented in FETCH.
                ir_d    = instruction_t'(imem_rdata);
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = EXECUTE;
            end
            EXECUTE: begin
                if (is_ld || is_st) begin
                    state_d = MEMORY_ACCESS;
                end else if (is_alu || is_mov) begin
                    state_d = WRITE_BACK;
                end else begin
                    // Flow control and illegal opcodes finish here.
                    if (is_flow && br_taken) begin
                        pc_d = pc_q + br_off;
                    end
                    state_d = FETCH;
                end
            end
            MEMORY_ACCESS: begin
                state_d = is_ld ? WRITE_BACK : FETCH;
            end
            WRITE_BACK: begin
                if (is_alu) begin
                    z_d = alu_zero;
                end
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are qualified with !rst so a reset landing in
    // MEMORY_ACCESS or WRITE_BACK cancels the side effect in that cycle.
    // ------------------------------------------------------------------
    assign imem_addr  = pc_q;
    assign state      = state_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign z_flag     = z_q;

    assign rf_raddr_a = ir_q.operand.regs.dst;
    assign rf_raddr_b = ir_q.operand.regs.src;
    assign rf_waddr   = ir_q.operand.regs.dst;
    assign alu_op     = alu_op_c;
    assign alu_b_sel  = is_alu_imm;
    assign imm        = {{(DATA_WIDTH-2){1'b0}}, ir_q.operand.imm2.val};
    assign wb_sel     = wb_sel_c;

    // WRITE_BACK is only reachable by instructions that write a register.
    assign rf_we      = !rst && (state_q == WRITE_BACK);
    assign dmem_re    = !rst && (state_q == MEMORY_ACCESS) && is_ld;
    assign dmem_we    = !rst && (state_q == MEMORY_ACCESS) && is_st;
    assign illegal    = !rst && (state_q == EXECUTE) && is_ill;
    assign instr_done = !rst && ((state_q == WRITE_BACK)
                              || ((state_q == MEMORY_ACCESS) && is_st)
                              || ((state_q == EXECUTE) && (is_flow || is_ill)));

endmodule
